// File: rtl/pe_operand_feeder_if.sv
// pe_operand_feeder_if
//   Bundles the command, operand, PE-side and result signals of the MAC PE
//   operand feeder.
//   Modports:
//     master - job source / PE / result consumer side (drives cmd, op, pe_c, res_ready)
//     slave  - the feeder itself (drives readies, PE operands/clear, result, busy)
//   Signals:
//     cmd_valid/cmd_ready/cmd_len   job command handshake, length in pairs
//     op_valid/op_ready/op_a/op_b   operand pair handshake
//     pe_rst/pe_a/pe_b              clear and operands towards the PE
//     pe_c                          PE accumulator value
//     res_valid/res_ready/res_data  result handshake
//     busy                          feeder is not idle
interface pe_operand_feeder_if #(
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic             pe_rst;
  logic [DW-1:0]    pe_a;
  logic [DW-1:0]    pe_b;
  logic [AW-1:0]    pe_c;
  logic             res_valid;
  logic             res_ready;
  logic [AW-1:0]    res_data;
  logic             busy;

  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, pe_c, res_ready,
    input  cmd_ready, op_ready, pe_rst, pe_a, pe_b, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, pe_c, res_ready,
    output cmd_ready, op_ready, pe_rst, pe_a, pe_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder
//   Sequencer in front of an accumulating MAC PE (c <= c + a*b each clock,
//   active-high clear). Takes a job of N operand pairs, clears the PE, streams
//   the pairs in (zeros on bubble cycles), then captures the accumulator and
//   offers it on a valid/ready result port.
//   Ports:
//     i_clk    system clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      pe_operand_feeder_if.slave (command, operands, PE, result)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a job command (cmd_ready=1)
//   CLEAR   | PE clear asserted for one cycle, operands zero
//   STREAM  | accepting operand pairs, forwarding them to the PE
//   SETTLE  | PE absorbs the last pair
//   CAPTURE | PE accumulator is final; latch it into res_data
//   DONE    | result offered until res_ready
module pe_operand_feeder #(
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int LEN_W = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  pe_operand_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_count;
  logic             r_pe_rst;
  logic [DW-1:0]    r_pe_a;
  logic [DW-1:0]    r_pe_b;
  logic             r_res_valid;
  logic [AW-1:0]    r_res_data;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_count_nxt;
  logic             w_pe_rst_nxt;
  logic [DW-1:0]    w_pe_a_nxt;
  logic [DW-1:0]    w_pe_b_nxt;
  logic             w_res_valid_nxt;
  logic [AW-1:0]    w_res_data_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      // PE is held cleared from reset until the first job's CLEAR finishes.
      r_pe_rst    <= 1'b1;
      r_pe_a      <= '0;
      r_pe_b      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_pe_rst    <= w_pe_rst_nxt;
      r_pe_a      <= w_pe_a_nxt;
      r_pe_b      <= w_pe_b_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_pe_rst_nxt    = r_pe_rst;
    // Operands default to zero so every non-handshake cycle adds nothing.
    w_pe_a_nxt      = '0;
    w_pe_b_nxt      = '0;
    w_res_valid_nxt = r_res_valid;
    w_res_data_nxt  = r_res_data;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_count_nxt = bus.cmd_len;
          if (bus.cmd_len != '0) begin
            w_pe_rst_nxt = 1'b1;
            w_state_nxt  = ST_CLEAR;
          end else begin
            // Empty job: report zero without touching the PE.
            w_res_data_nxt  = '0;
            w_res_valid_nxt = 1'b1;
            w_state_nxt     = ST_DONE;
          end
        end
      end
      ST_CLEAR: begin
        w_pe_rst_nxt = 1'b0;
        w_state_nxt  = ST_STREAM;
      end
      ST_STREAM: begin
        if (bus.op_valid) begin
          w_pe_a_nxt  = bus.op_a;
          w_pe_b_nxt  = bus.op_b;
          w_count_nxt = r_count - 1'b1;
          if (r_count == LEN_W'(1)) begin
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_res_data_nxt  = bus.pe_c;
        w_res_valid_nxt = 1'b1;
        w_state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.op_ready  = (r_state == ST_STREAM);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.pe_rst    = r_pe_rst;
  assign bus.pe_a      = r_pe_a;
  assign bus.pe_b      = r_pe_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;

endmodule
